pheap_root_ctrl: RTL

PHEAP_ROOT_CTRL -- requirements
Module: pheap_root_ctrl

---
 rtl/pheap_root_ctrl.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/pheap_root_ctrl.sv
// Root-level controller of a pipelined max-heap: holds the root entry and free capacity,
// reads the two level-2 children, and issues one push-down command per operation.
module pheap_root_ctrl #(
  parameter int KEY_W  = 16,
  parameter int VAL_W  = 16,
  parameter int LEVELS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [KEY_W-1:0]  in_key,
  input  logic [VAL_W-1:0]  in_val,
  input  logic              cL_active,
  input  logic              cR_active,
  input  logic [LEVELS-2:0] cL_cap,
  input  logic [LEVELS-2:0] cR_cap,
  input  logic [KEY_W-1:0]  cL_key,
  input  logic [KEY_W-1:0]  cR_key,
  input  logic [VAL_W-1:0]  cL_val,
  input  logic [VAL_W-1:0]  cR_val,
  output logic              rd_en,
  output logic              nl_valid,
  input  logic              nl_ready,
  output logic [1:0]        nl_op,
  output logic              nl_pos,
  output logic [KEY_W-1:0]  nl_key,
  output logic [VAL_W-1:0]  nl_val,
  output logic              out_valid,
  output logic [KEY_W-1:0]  out_key,
  output logic [VAL_W-1:0]  out_val,
  output logic              head_valid,
  output logic [KEY_W-1:0]  head_key,
  output logic [VAL_W-1:0]  head_val,
  output logic              busy,
  output logic              err,
  output logic              full,
  output logic              empty,
  output logic [LEVELS-1:0] count
);

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_ENQ = 2'b01;
  localparam logic [1:0] OP_DEQ = 2'b10;
  localparam logic [1:0] OP_REP = 2'b11;
  localparam logic [LEVELS-1:0] MAX_CAP = '1;
  localparam logic [LEVELS-1:0] CAP_ONE = {{(LEVELS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_PUSH} state_t;

  state_t            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [KEY_W-1:0]  in_key_q, in_key_d;
  logic [VAL_W-1:0]  in_val_q, in_val_d;
  logic              root_act_q, root_act_d;
  logic [KEY_W-1:0]  root_key_q, root_key_d;
  logic [VAL_W-1:0]  root_val_q, root_val_d;
  logic [LEVELS-1:0] cap_q, cap_d;
  logic              cl_act_q, cl_act_d, cr_act_q, cr_act_d;
  logic [LEVELS-2:0] cl_cap_q, cl_cap_d, cr_cap_q, cr_cap_d;
  logic [KEY_W-1:0]  cl_key_q, cl_key_d, cr_key_q, cr_key_d;
  logic [VAL_W-1:0]  cl_val_q, cl_val_d, cr_val_q, cr_val_d;
  logic [1:0]        nl_op_q, nl_op_d;
  logic              nl_pos_q, nl_pos_d;
  logic [KEY_W-1:0]  nl_key_q, nl_key_d;
  logic [VAL_W-1:0]  nl_val_q, nl_val_d;

  logic              rd_en_c, err_c, out_valid_c;
  logic              pick_r, any_child, live;
  logic [KEY_W-1:0]  best_key;
  logic [VAL_W-1:0]  best_val;

  // Larger active child wins; equal keys go left.
  assign pick_r    = cr_act_q && (!cl_act_q || (cr_key_q > cl_key_q));
  assign any_child = cl_act_q || cr_act_q;
  assign best_key  = pick_r ? cr_key_q : cl_key_q;
  assign best_val  = pick_r ? cr_val_q : cl_val_q;

  always_comb begin
    state_d = state_q;   op_d = op_q;   in_key_d = in_key_q;   in_val_d = in_val_q;
    root_act_d = root_act_q;   root_key_d = root_key_q;   root_val_d = root_val_q;
    cap_d = cap_q;
    cl_act_d = cl_act_q;   cr_act_d = cr_act_q;   cl_cap_d = cl_cap_q;   cr_cap_d = cr_cap_q;
    cl_key_d = cl_key_q;   cr_key_d = cr_key_q;   cl_val_d = cl_val_q;   cr_val_d = cr_val_q;
    nl_op_d = nl_op_q;   nl_pos_d = nl_pos_q;   nl_key_d = nl_key_q;   nl_val_d = nl_val_q;
    rd_en_c = 1'b0;   err_c = 1'b0;   out_valid_c = 1'b0;
    case (state_q)
      S_IDLE: if (start && (op != OP_NOP)) begin
        rd_en_c = 1'b1;
        op_d = op;   in_key_d = in_key;   in_val_d = in_val;
        state_d = S_READ;
      end
      S_READ: begin
        cl_act_d = cL_active;   cr_act_d = cR_active;   cl_cap_d = cL_cap;   cr_cap_d = cR_cap;
        cl_key_d = cL_key;   cr_key_d = cR_key;   cl_val_d = cL_val;   cr_val_d = cR_val;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_IDLE;
        case (op_q)
          OP_ENQ: if (cap_q == '0) begin
            err_c = 1'b1;
          end else if (!root_act_q) begin
            root_act_d = 1'b1;   root_key_d = in_key_q;   root_val_d = in_val_q;
            cap_d = cap_q - CAP_ONE;
          end else begin
            cap_d = cap_q - CAP_ONE;
            nl_op_d = OP_ENQ;   nl_pos_d = (cr_cap_q > cl_cap_q);   state_d = S_PUSH;
            if (in_key_q > root_key_q) begin
              root_key_d = in_key_q;   root_val_d = in_val_q;
              nl_key_d = root_key_q;   nl_val_d = root_val_q;
            end else begin
              nl_key_d = in_key_q;   nl_val_d = in_val_q;
            end
          end
          OP_DEQ: if (!root_act_q) begin
            err_c = 1'b1;
          end else begin
            out_valid_c = 1'b1;
            if (cap_q != MAX_CAP) cap_d = cap_q + CAP_ONE;
            if (!any_child) begin
              root_act_d = 1'b0;   root_key_d = '0;   root_val_d = '0;
            end else begin
              root_key_d = best_key;   root_val_d = best_val;
              nl_op_d = OP_DEQ;   nl_pos_d = pick_r;   nl_key_d = best_key;   nl_val_d = best_val;
              state_d = S_PUSH;
            end
          end
          OP_REP: if (!root_act_q) begin
            err_c = 1'b1;
          end else begin
            out_valid_c = 1'b1;
            if (!any_child || (in_key_q >= best_key)) begin
              root_key_d = in_key_q;   root_val_d = in_val_q;
            end else begin
              root_key_d = best_key;   root_val_d = best_val;
              nl_op_d = OP_REP;   nl_pos_d = pick_r;   nl_key_d = in_key_q;   nl_val_d = in_val_q;
              state_d = S_PUSH;
            end
          end
          default: ;
        endcase
      end
      S_PUSH: if (nl_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;   op_q <= OP_NOP;   in_key_q <= '0;   in_val_q <= '0;
      root_act_q <= 1'b0;   root_key_q <= '0;   root_val_q <= '0;   cap_q <= MAX_CAP;
      cl_act_q <= 1'b0;   cr_act_q <= 1'b0;   cl_cap_q <= '0;   cr_cap_q <= '0;
      cl_key_q <= '0;   cr_key_q <= '0;   cl_val_q <= '0;   cr_val_q <= '0;
      nl_op_q <= OP_NOP;   nl_pos_q <= 1'b0;   nl_key_q <= '0;   nl_val_q <= '0;
    end else begin
      state_q <= state_d;   op_q <= op_d;   in_key_q <= in_key_d;   in_val_q <= in_val_d;
      root_act_q <= root_act_d;   root_key_q <= root_key_d;   root_val_q <= root_val_d;
      cap_q <= cap_d;
      cl_act_q <= cl_act_d;   cr_act_q <= cr_act_d;   cl_cap_q <= cl_cap_d;   cr_cap_q <= cr_cap_d;
      cl_key_q <= cl_key_d;   cr_key_q <= cr_key_d;   cl_val_q <= cl_val_d;   cr_val_q <= cr_val_d;
      nl_op_q <= nl_op_d;   nl_pos_q <= nl_pos_d;   nl_key_q <= nl_key_d;   nl_val_q <= nl_val_d;
    end
  end

  // Outputs are forced quiet while rst is high, not only after the reset edge.
  assign live       = !rst;
  assign busy       = live && (state_q != S_IDLE);
  assign rd_en      = live && rd_en_c;
  assign err        = live && err_c;
  assign out_valid  = live && out_valid_c;
  assign out_key    = out_valid ? root_key_q : '0;
  assign out_val    = out_valid ? root_val_q : '0;
  assign nl_valid   = live && (state_q == S_PUSH);
  assign nl_op      = nl_valid ? nl_op_q : OP_NOP;
  assign nl_pos     = nl_valid && nl_pos_q;
  assign nl_key     = nl_valid ? nl_key_q : '0;
  assign nl_val     = nl_valid ? nl_val_q : '0;
  assign head_valid = live && root_act_q;
  assign head_key   = live ? root_key_q : '0;
  assign head_val   = live ? root_val_q : '0;
  assign full       = live && (cap_q == '0);
  assign empty      = !live || (cap_q == MAX_CAP);
  assign count      = live ? (MAX_CAP - cap_q) : '0;

endmodule
